// File: rtl/dac_pkg.sv
// Shared constants and types for the cartridge I2S DAC driver.
//   CTR_W      : width of the free-running frame divider
//   *_BIT      : divider bit that drives each DAC clock line
//   SLOT_BITS  : sclk periods per lrck half-frame
//   pcm_pair_t : {left, right} sample pair at the default 16-bit width
//   i2s_bit    : picks the serial bit for slot index k out of an MSB-first slot word
package dac_pkg;

    localparam int CTR_W     = 10;
    localparam int MCLK_BIT  = 1;
    localparam int SCLK_BIT  = 3;
    localparam int LRCK_BIT  = 9;
    localparam int SLOT_BITS = 32;
    localparam int PCM_SW    = 16;

    typedef struct packed {
        logic [PCM_SW-1:0] l;
        logic [PCM_SW-1:0] r;
    } pcm_pair_t;

    // slot_word[SLOT_BITS-1] is slot bit 0, slot_word[0] is slot bit 31.
    function automatic logic i2s_bit(input logic [SLOT_BITS-1:0] slot_word,
                                     input logic [4:0]           k);
        return slot_word[~k];
    endfunction

endpackage

// File: rtl/dac_i2s_tx_fifo.sv
// pcm_fifo: synchronous sample FIFO with exact occupancy.
//   clk, rst_n : negedge clock, async active-low reset (pointers/level only)
//   push/wr_data : write port, caller guarantees ready
//   pop/rd_data  : read port, rd_data shows the head, caller guarantees !empty
//   empty, ready : level == 0, level < DEPTH (both from registered level)
//   level        : occupancy 0..DEPTH
module pcm_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           wr_data,
    input  logic                   pop,
    output logic [W-1:0]           rd_data,
    output logic                   empty,
    output logic                   ready,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  mem [DEPTH];

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + (PW+1)'(1);
                2'b01:   level <= level - (PW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (level == '0);
    assign ready   = (level < (PW+1)'(DEPTH));

endmodule

// File: rtl/dac_i2s_tx.sv
// dac_i2s_tx: buffers stereo PCM pairs and serialises them as I2S on the
// cartridge DAC bundle. All state moves on the falling edge of clk.
//   en          : 0 holds the divider at 0 and idles every DAC line
//   mute        : sampled at the frame latch, transmits zero frames
//   s_valid/s_data/s_ready : {left,right} sample input, ready = FIFO not full
//   urun/urun_clr : sticky underrun flag (set wins over clear)
//   level       : FIFO occupancy
//   dac_mclk/sclk/lrck : divider bits 1/3/9, dac_sdin : registered serial data
module dac_i2s_tx
    import dac_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SW         = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        mute,
    input  logic                        s_valid,
    input  logic [2*SW-1:0]             s_data,
    output logic                        s_ready,
    input  logic                        urun_clr,
    output logic                        urun,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        dac_mclk,
    output logic                        dac_sclk,
    output logic                        dac_lrck,
    output logic                        dac_sdin
);

    localparam int NS_W = CTR_W - SCLK_BIT - 1;
    localparam logic [NS_W-1:0] SLOT_ONE = NS_W'(1);

    logic [CTR_W-1:0]     ctr;
    logic [SW-1:0]        frame_l;
    logic [SW-1:0]        frame_r;
    logic                 sdin_q;
    logic                 urun_q;
    logic [2*SW-1:0]      head;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 frame_edge;
    logic                 sdin_edge;
    logic [NS_W-1:0]      nxt_slot;
    logic [SLOT_BITS-1:0] slot_word;
    logic                 nxt_bit;

    pcm_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (2*SW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (s_data),
        .pop     (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .ready   (s_ready),
        .level   (level)
    );

    always_comb begin
        frame_edge = en && (ctr == '1);
        sdin_edge  = en && (ctr[SCLK_BIT:0] == '1);
        push       = s_valid && s_ready;
        pop        = frame_edge && !fifo_empty;
        // sdin only updates when the low divider bits are all ones, so
        // (ctr+1)[9:4] is simply ctr[9:4]+1 there: {channel, slot index}.
        nxt_slot   = ctr[CTR_W-1:SCLK_BIT+1] + SLOT_ONE;
        // Left-justify the word one bit below the slot MSB so slot bit k
        // carries sample[SW-k]; slot bit 0 and bits past SW read zero.
        slot_word  = SLOT_BITS'({1'b0, (nxt_slot[NS_W-1] ? frame_r : frame_l)})
                     << (SLOT_BITS - 1 - SW);
        nxt_bit    = i2s_bit(slot_word, nxt_slot[4:0]);
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr     <= '0;
            frame_l <= '0;
            frame_r <= '0;
            sdin_q  <= 1'b0;
            urun_q  <= 1'b0;
        end else begin
            if (frame_edge && fifo_empty) urun_q <= 1'b1;
            else if (urun_clr)            urun_q <= 1'b0;

            if (!en) begin
                ctr     <= '0;
                frame_l <= '0;
                frame_r <= '0;
                sdin_q  <= 1'b0;
            end else begin
                ctr <= ctr + CTR_W'(1);
                if (sdin_edge) sdin_q <= nxt_bit;
                if (frame_edge) begin
                    if (!fifo_empty && !mute) begin
                        {frame_l, frame_r} <= head;
                    end else begin
                        frame_l <= '0;
                        frame_r <= '0;
                    end
                end
            end
        end
    end

    assign urun     = urun_q;
    assign dac_mclk = ctr[MCLK_BIT];
    assign dac_sclk = ctr[SCLK_BIT];
    assign dac_lrck = ctr[LRCK_BIT];
    assign dac_sdin = sdin_q;

endmodule

// File: tb/tb_dac_i2s_tx.sv
// Bench for dac_i2s_tx: a directed sequence drives samples, a reference model
// queue holds the pairs still to be framed, and a monitor compares clock lines,
// flags, level and each captured 64-bit frame against that model.
module tb_dac_i2s_tx;
    import dac_pkg::*;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   en;
    logic                   mute;
    logic                   s_valid;
    logic [2*PCM_SW-1:0]    s_data;
    logic                   s_ready;
    logic                   urun_clr;
    logic                   urun;
    logic [2:0]             level;
    logic                   dac_mclk;
    logic                   dac_sclk;
    logic                   dac_lrck;
    logic                   dac_sdin;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dac_i2s_tx #(
        .FIFO_DEPTH (DEPTH),
        .SW         (PCM_SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mute     (mute),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .urun_clr (urun_clr),
        .urun     (urun),
        .level    (level),
        .dac_mclk (dac_mclk),
        .dac_sclk (dac_sclk),
        .dac_lrck (dac_lrck),
        .dac_sdin (dac_sdin)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected serial frame: bit index {lrck, k}; k=1..16 carries sample[16-k].
    function automatic logic [63:0] exp_frame(input pcm_pair_t p);
        logic [63:0]       e;
        logic [PCM_SW-1:0] wl;
        logic [PCM_SW-1:0] wr;
        e  = '0;
        wl = p.l;
        wr = p.r;
        for (int unsigned k = 1; k <= PCM_SW; k++) begin
            e  = e | (64'(wl[PCM_SW-1]) << k) | (64'(wr[PCM_SW-1]) << (32 + k));
            wl = wl << 1;
            wr = wr << 1;
        end
        return e;
    endfunction

    // Reference model: divider, frame in flight, underrun flag, pending pairs.
    logic [9:0] m_ctr  = '0;
    pcm_pair_t  m_cur  = '0;
    logic       m_urun = 1'b0;
    pcm_pair_t  sb_q[$];
    pcm_pair_t  m_pop;
    logic       m_push;
    logic       m_latch;
    logic       m_empty;

    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ctr  = '0;
                m_cur  = '0;
                m_urun = 1'b0;
                sb_q.delete();
            end else begin
                m_push  = s_valid && (sb_q.size() < DEPTH);
                m_latch = en && (m_ctr == 10'd1023);
                m_empty = (sb_q.size() == 0);
                if (m_latch) begin
                    if (!m_empty) begin
                        m_pop = sb_q.pop_front();
                        m_cur = mute ? pcm_pair_t'('0) : m_pop;
                    end else begin
                        m_cur = '0;
                    end
                end else if (!en) begin
                    m_cur = '0;
                end
                if (m_latch && m_empty) m_urun = 1'b1;
                else if (urun_clr)      m_urun = 1'b0;
                if (m_push) sb_q.push_back(pcm_pair_t'(s_data));
                m_ctr = en ? m_ctr + 10'd1 : 10'd0;
            end
        end
    end

    // Monitor: sampled on posedge, half a period away from the active edge.
    logic [63:0] cap      = '0;
    logic        prev_sdin = 1'b0;

    initial begin
        @(negedge clk);
        forever begin
            @(posedge clk);
            chk("pins",
                64'({dac_mclk, dac_sclk, dac_lrck, urun, s_ready, level}),
                64'({m_ctr[1], m_ctr[3], m_ctr[9], m_urun, (sb_q.size() < DEPTH), 3'(sb_q.size())}));
            if (dac_sdin !== prev_sdin)
                chk("sdin_edge", 64'(m_ctr[3:0]), 64'(4'd0));
            prev_sdin = dac_sdin;
            if (m_ctr[3:0] == 4'd8) cap[{m_ctr[9], m_ctr[8:4]}] = dac_sdin;
            if (m_ctr == 10'd1023) chk("frame", cap, exp_frame(m_cur));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        s_data  = {l, r};
        s_valid = 1'b1;
        step(1);
        s_valid = 1'b0;
    endtask

    task automatic clr_urun();
        urun_clr = 1'b1;
        step(1);
        urun_clr = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        mute     = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        urun_clr = 1'b0;
        step(2);
        chk("reset_out", 64'({dac_mclk, dac_sclk, dac_lrck, dac_sdin, urun, s_ready, level}),
            64'(9'b0_0000_1000));
        rst_n = 1'b1;
        step(1);

        // Idle run with no samples: underrun after the first wrap.
        en = 1'b1;
        step(1023);
        chk("urun_before_wrap", 64'(urun), 64'(0));
        step(1);
        chk("urun_after_wrap", 64'(urun), 64'(1));
        clr_urun();
        chk("urun_clr", 64'(urun), 64'(0));

        // Single pair, transmitted in the second frame after enable.
        en = 1'b0;
        step(1);
        push_pair(16'h8001, 16'h7FFE);
        chk("level_one", 64'(level), 64'(1));
        en = 1'b1;
        step(1024);
        chk("level_popped", 64'(level), 64'(0));
        step(1024);
        chk("urun_drained", 64'(urun), 64'(1));

        // Fill to full with the serializer off; fifth push is refused.
        en = 1'b0;
        step(1);
        clr_urun();
        push_pair(16'hA000, 16'h000A);
        push_pair(16'hA111, 16'h111A);
        push_pair(16'hA222, 16'h222A);
        push_pair(16'hA333, 16'h333A);
        push_pair(16'hDEAD, 16'hBEEF);
        chk("full_ready", 64'(s_ready), 64'(0));
        chk("full_level", 64'(level), 64'(4));
        en = 1'b1;
        step(1023);
        chk("full_hold_level", 64'(level), 64'(4));
        chk("full_hold_ready", 64'(s_ready), 64'(0));
        step(1);
        chk("first_pop_level", 64'(level), 64'(3));
        chk("first_pop_ready", 64'(s_ready), 64'(1));

        // Push on the same edge as a pop with level 2; write pointer wraps.
        step(1024);
        chk("level_two", 64'(level), 64'(2));
        step(1023);
        push_pair(16'h5A5A, 16'hC3C3);
        chk("push_pop_level", 64'(level), 64'(2));
        step(3072);
        chk("wrap_drained", 64'(level), 64'(0));
        chk("wrap_urun", 64'(urun), 64'(1));

        // Mute: zero frames, FIFO drains, no underrun while samples remain.
        en = 1'b0;
        step(1);
        clr_urun();
        mute = 1'b1;
        push_pair(16'h1234, 16'h1234);
        push_pair(16'h1234, 16'h1234);
        push_pair(16'h1234, 16'h1234);
        en = 1'b1;
        step(1024);
        chk("mute_level2", 64'(level), 64'(2));
        step(2048);
        chk("mute_level0", 64'(level), 64'(0));
        chk("mute_no_urun", 64'(urun), 64'(0));
        step(1024);
        chk("mute_urun", 64'(urun), 64'(1));
        mute = 1'b0;

        // Reset mid-frame discards the FIFO and restarts the divider.
        en = 1'b0;
        step(1);
        clr_urun();
        push_pair(16'h0F0F, 16'hF0F0);
        push_pair(16'h1111, 16'h2222);
        push_pair(16'h3333, 16'h4444);
        en = 1'b1;
        step(500);
        chk("pre_reset_level", 64'(level), 64'(3));
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out", 64'({dac_mclk, dac_sclk, dac_lrck, dac_sdin, urun, s_ready, level}),
            64'(9'b0_0000_1000));
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("restart_ctr2", 64'({dac_mclk, dac_sclk, dac_lrck}), 64'(3'b100));
        step(6);
        chk("restart_ctr8", 64'({dac_mclk, dac_sclk, dac_lrck}), 64'(3'b010));
        chk("restart_level", 64'(level), 64'(0));
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
